frame_compositor: RTL and testbench

- Parametrised successor to the single-bike pixel combiner: a pipelined frame-buffer reader plus N-layer sprite overlay that produces one colour enum per pixel clock for the colour mapper.
- Owns a dual-port packed frame RAM: a masked word write port for game logic, an internal clear engine, and a registered read path with fixed latency.
- Sits between the VGA controller (DrawX/DrawY/de) and the palette lookup.

---
 rtl/frame_comp_pkg.sv | 26 ++
 rtl/frame_compositor_if.sv | 15 +
 rtl/frame_ram_dp.sv | 33 +++
 rtl/frame_compositor.sv | 187 ++++++++++++++++++
 tb/tb_frame_compositor.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_comp_pkg.sv
// Shared types and constants for the frame compositor: pixel colour type,
// clear-engine states and the packed-word lane extractor.
package frame_comp_pkg;

  localparam int BPP    = 4;
  localparam int WORD_W = 16;
  localparam int PPW    = WORD_W / BPP;
  localparam int LANE_W = $clog2(PPW);

  typedef logic [BPP-1:0] color_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } clr_state_t;

  localparam color_t TRANSPARENT = 4'hF;
  localparam color_t BLANK_COLOR = 4'h0;

  // Lane 0 is the most significant pixel of the word.
  function automatic color_t lane_extract(input logic [WORD_W-1:0] word,
                                          input logic [LANE_W-1:0] lane);
    return word[WORD_W-1 - int'(lane)*BPP -: BPP];
  endfunction

endpackage

// File: rtl/frame_compositor_if.sv
// Masked word-write port into the frame buffer (valid/ready handshake).
interface frame_compositor_if #(
    parameter int ADDR_W = 17
) ();

    logic                              wr_valid;
    logic                              wr_ready;
    logic [ADDR_W-1:0]                 wr_addr;
    logic [frame_comp_pkg::WORD_W-1:0] wr_data;
    logic [frame_comp_pkg::PPW-1:0]    wr_mask;

    modport master (output wr_valid, wr_addr, wr_data, wr_mask, input wr_ready);
    modport slave  (input wr_valid, wr_addr, wr_data, wr_mask, output wr_ready);

endinterface

// File: rtl/frame_ram_dp.sv
// Simple dual-port frame RAM: per-lane masked write port, synchronous
// read-first read port.
module frame_ram_dp #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 76800,
    parameter int PPW    = 4,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LANE_BITS = WORD_W / PPW
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [PPW-1:0]    wmask,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM, and the
    // non-blocking write/read pair gives read-first behaviour on a collision.
    always_ff @(posedge clk) begin
        for (int k = 0; k < PPW; k++) begin
            if (we && wmask[k]) begin
                mem[waddr][WORD_W-1 - k*LANE_BITS -: LANE_BITS] <=
                    wdata[WORD_W-1 - k*LANE_BITS -: LANE_BITS];
            end
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/frame_compositor.sv
// Frame-buffer reader with N-layer sprite overlay, 3-cycle pixel pipeline and
// clear engine. Optional write-to-read forwarding: FRAME_COMPOSITOR_WRFWD_EN.
module frame_compositor
    import frame_comp_pkg::*;
#(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int N_LAYERS = 2,
    localparam int DEPTH  = H_RES * V_RES / PPW,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      de,
    input  logic [9:0]                DrawX,
    input  logic [9:0]                DrawY,
    input  logic [N_LAYERS*BPP-1:0]   layer_color,
    frame_compositor_if.slave         wr,
    input  logic                      clear_start,
    input  color_t                    clear_color,
    output logic                      clear_busy,
    output color_t                    color_enum,
    output logic                      color_valid
);

    localparam int                LIN_W     = ADDR_W + LANE_W;
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        state;
    logic [ADDR_W-1:0] clr_addr;
    logic [WORD_W-1:0] clr_word;

    logic              wr_fire;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [PPW-1:0]    ram_wmask;
    logic [WORD_W-1:0] rd_word;

    assign wr.wr_ready = Reset_n && (state == IDLE) && !clear_start;
    // Out-of-range addresses complete the handshake but never reach the RAM.
    assign wr_fire = wr.wr_valid && wr.wr_ready && ({1'b0, wr.wr_addr} < DEPTH_L);

    // NOTE: every output of a combinational block gets a default first so no
    // path through it can infer a latch.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = wr.wr_addr;
        ram_wdata = wr.wr_data;
        ram_wmask = wr.wr_mask;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = clr_word;
            ram_wmask = '1;
        end else if (wr_fire) begin
            ram_we = 1'b1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= IDLE;
            clr_addr   <= '0;
            clr_word   <= '0;
            clear_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: if (clear_start) begin
                    state      <= CLEAR;
                    clr_addr   <= '0;
                    clr_word   <= {PPW{clear_color}};
                    clear_busy <= 1'b1;
                end
                CLEAR: if (clr_addr == LAST_ADDR) begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end else begin
                    clr_addr <= clr_addr + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic              in_range;
    logic [LIN_W-1:0]  linear;
    logic [ADDR_W-1:0] pix_word;
    logic [LANE_W-1:0] pix_lane;

    assign in_range = (int'(DrawX) < H_RES) && (int'(DrawY) < V_RES);
    assign linear   = LIN_W'(DrawY) * LIN_W'(H_RES) + LIN_W'(DrawX);
    assign pix_word = ADDR_W'(linear / LIN_W'(PPW));
    assign pix_lane = LANE_W'(linear % LIN_W'(PPW));

    logic                    s1_de, s1_in_range, s2_de, s2_in_range;
    logic [ADDR_W-1:0]       s1_addr;
    logic [LANE_W-1:0]       s1_lane, s2_lane;
    logic [N_LAYERS*BPP-1:0] s1_layers, s2_layers;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_de       <= 1'b0;
            s1_in_range <= 1'b0;
            s1_addr     <= '0;
            s1_lane     <= '0;
            s1_layers   <= '0;
            s2_de       <= 1'b0;
            s2_in_range <= 1'b0;
            s2_lane     <= '0;
            s2_layers   <= '0;
        end else begin
            s1_de       <= de;
            s1_in_range <= in_range;
            s1_lane     <= pix_lane;
            s1_layers   <= layer_color;
            if (de && in_range) s1_addr <= pix_word;
            s2_de       <= s1_de;
            s2_in_range <= s1_in_range;
            s2_lane     <= s1_lane;
            s2_layers   <= s1_layers;
        end
    end

    frame_ram_dp #(.WORD_W(WORD_W), .DEPTH(DEPTH), .PPW(PPW)) u_ram (
        .clk   (Clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .wmask (ram_wmask),
        .raddr (s1_addr),
        .rdata (rd_word)
    );

    logic [WORD_W-1:0] s2_word;
    color_t            pix_out;

`ifdef FRAME_COMPOSITOR_WRFWD_EN
    logic              fwd_hit;
    logic [WORD_W-1:0] fwd_data;
    logic [PPW-1:0]    fwd_mask;

    // Capture the write that lands on the word being read this cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fwd_hit  <= 1'b0;
            fwd_data <= '0;
            fwd_mask <= '0;
        end else begin
            fwd_hit  <= ram_we && (ram_waddr == s1_addr);
            fwd_data <= ram_wdata;
            fwd_mask <= ram_wmask;
        end
    end

    always_comb begin
        s2_word = rd_word;
        for (int k = 0; k < PPW; k++) begin
            if (fwd_hit && fwd_mask[k]) begin
                s2_word[WORD_W-1 - k*BPP -: BPP] = fwd_data[WORD_W-1 - k*BPP -: BPP];
            end
        end
    end
`else
    assign s2_word = rd_word;
`endif

    // Highest index first so the lowest opaque layer has the final say.
    always_comb begin
        pix_out = lane_extract(s2_word, s2_lane);
        for (int i = N_LAYERS - 1; i >= 0; i--) begin
            if (s2_layers[i*BPP +: BPP] != TRANSPARENT) pix_out = s2_layers[i*BPP +: BPP];
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            color_enum  <= BLANK_COLOR;
            color_valid <= 1'b0;
        end else begin
            color_valid <= s2_de && s2_in_range;
            color_enum  <= (s2_de && s2_in_range) ? pix_out : BLANK_COLOR;
        end
    end

endmodule

// File: tb/tb_frame_compositor.sv
// Directed bench for frame_compositor: stimulus pushes expected pixels into a
// scoreboard queue, a negedge monitor pops them when their 3-cycle slot arrives.
module tb_frame_compositor;
    import frame_comp_pkg::*;

    localparam int H      = 640;
    localparam int V      = 480;
    localparam int DEPTH  = H * V / PPW;
    localparam int ADDR_W = $clog2(DEPTH);

`ifdef FRAME_COMPOSITOR_WRFWD_EN
    localparam logic [3:0] COLL_EXP = 4'h1;
`else
    localparam logic [3:0] COLL_EXP = 4'hA;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       de;
    logic [9:0] DrawX, DrawY;
    logic [7:0] layer_color;
    logic       clear_start;
    color_t     clear_color;
    logic       clear_busy;
    color_t     color_enum;
    logic       color_valid;

    frame_compositor_if #(.ADDR_W(ADDR_W)) wr_if ();

    frame_compositor #(.H_RES(H), .V_RES(V), .N_LAYERS(2)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .de          (de),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .layer_color (layer_color),
        .wr          (wr_if),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .color_enum  (color_enum),
        .color_valid (color_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int         due;
        int         id;
        logic [3:0] c;
        logic       v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_err  = 0;
    int   px_id  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            check($sformatf("pixel %0d color_enum", mon_e.id), 32'(color_enum), 32'(mon_e.c));
            check($sformatf("pixel %0d color_valid", mon_e.id), 32'(color_valid), 32'(mon_e.v));
        end
    end

    // Drive one pixel for one cycle and queue its expected output.
    task automatic px(input int x, input int y, input logic d, input logic [7:0] lay,
                      input logic [3:0] ec, input logic ev);
        exp_t e;
        DrawX       = 10'(x);
        DrawY       = 10'(y);
        de          = d;
        layer_color = lay;
        e.due = cyc + 3;
        e.id  = px_id;
        e.c   = ec;
        e.v   = ev;
        px_id++;
        sb.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic set_wr(input logic v, input int a, input logic [15:0] d, input logic [3:0] m);
        wr_if.wr_valid = v;
        wr_if.wr_addr  = ADDR_W'(a);
        wr_if.wr_data  = d;
        wr_if.wr_mask  = m;
    endtask

    task automatic idle(input int n);
        de = 1'b0;
        repeat (n) @(posedge Clk);
        #1;
    endtask

    int cnt;
    int guard;

    initial begin
        Reset_n     = 1'b0;
        de          = 1'b0;
        DrawX       = '0;
        DrawY       = '0;
        layer_color = 8'hFF;
        clear_start = 1'b0;
        clear_color = '0;
        set_wr(1'b1, 0, 16'h0, 4'h0);

        repeat (3) @(posedge Clk);
        #1;
        check("reset color_enum", 32'(color_enum), 32'(BLANK_COLOR));
        check("reset color_valid", 32'(color_valid), 0);
        check("reset clear_busy", 32'(clear_busy), 0);
        check("reset wr_ready", 32'(wr_if.wr_ready), 0);
        set_wr(1'b0, 0, 16'h0, 4'h0);

        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("wr_ready after reset", 32'(wr_if.wr_ready), 1);

        // Full-word write, then read back the four lanes in order.
        set_wr(1'b1, 0, 16'h1234, 4'hF);
        px(0, 0, 1'b0, 8'hFF, BLANK_COLOR, 1'b0);
        set_wr(1'b0, 0, 16'h0, 4'h0);
        px(0, 0, 1'b1, 8'hFF, 4'h1, 1'b1);
        px(1, 0, 1'b1, 8'hFF, 4'h2, 1'b1);
        px(2, 0, 1'b1, 8'hFF, 4'h3, 1'b1);
        px(3, 0, 1'b1, 8'hFF, 4'h4, 1'b1);

        // Layer priority: layer 0 is the low nibble.
        px(1, 0, 1'b1, 8'hF5, 4'h5, 1'b1);
        px(1, 0, 1'b1, 8'h7F, 4'h7, 1'b1);
        px(1, 0, 1'b1, 8'h79, 4'h9, 1'b1);

        // Range and display-enable handling.
        px(700, 0, 1'b1, 8'hFF, BLANK_COLOR, 1'b0);
        px(2, 0, 1'b0, 8'hFF, BLANK_COLOR, 1'b0);
        px(0, 480, 1'b1, 8'hFF, BLANK_COLOR, 1'b0);
        px(639, 479, 1'b1, 8'hF3, 4'h3, 1'b1);
        idle(5);

        // Clear beats a simultaneous write.
        clear_start = 1'b1;
        clear_color = 4'hA;
        set_wr(1'b1, 3, 16'h5555, 4'hF);
        #1;
        check("wr_ready with clear_start", 32'(wr_if.wr_ready), 0);
        @(posedge Clk);
        #1;
        clear_start = 1'b0;
        set_wr(1'b0, 0, 16'h0, 4'h0);
        cnt = 0;
        while (clear_busy === 1'b1 && cnt < DEPTH + 10) begin
            if (cnt == 5) check("wr_ready during clear", 32'(wr_if.wr_ready), 0);
            if (cnt == 10) begin
                clear_start = 1'b1;
                clear_color = 4'hB;
            end else begin
                clear_start = 1'b0;
            end
            cnt++;
            @(posedge Clk);
            #1;
        end
        clear_start = 1'b0;
        check("clear_busy cycle count", 32'(cnt), 32'(DEPTH));

        px(639, 479, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(0, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(12, 0, 1'b1, 8'hFF, 4'hA, 1'b1);

        // Masked writes: mask bit k selects pixel k of the word.
        set_wr(1'b1, 5, 16'hBBBB, 4'b0010);
        px(0, 0, 1'b0, 8'hFF, BLANK_COLOR, 1'b0);
        set_wr(1'b1, 6, 16'hBBBB, 4'b0100);
        px(0, 0, 1'b0, 8'hFF, BLANK_COLOR, 1'b0);
        set_wr(1'b1, DEPTH, 16'h1111, 4'hF);
        #1;
        check("wr_ready out-of-range addr", 32'(wr_if.wr_ready), 1);
        px(0, 0, 1'b0, 8'hFF, BLANK_COLOR, 1'b0);
        set_wr(1'b0, 0, 16'h0, 4'h0);
        px(20, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(21, 0, 1'b1, 8'hFF, 4'hB, 1'b1);
        px(22, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(23, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(24, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(25, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(26, 0, 1'b1, 8'hFF, 4'hB, 1'b1);
        px(27, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        idle(4);

        // Read of word 0 meets a write to word 0 at the RAM port.
        px(0, 0, 1'b1, 8'hFF, COLL_EXP, 1'b1);
        set_wr(1'b1, 0, 16'h1234, 4'b0011);
        px(1, 0, 1'b1, 8'hFF, 4'h2, 1'b1);
        set_wr(1'b0, 0, 16'h0, 4'h0);
        px(2, 0, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(0, 0, 1'b1, 8'hFF, 4'h1, 1'b1);
        idle(6);

        // Reset in the middle of a clear.
        clear_start = 1'b1;
        clear_color = 4'h3;
        @(posedge Clk);
        #1;
        clear_start = 1'b0;
        DrawX       = 10'd1;
        DrawY       = 10'd1;
        layer_color = 8'hF6;
        de          = 1'b1;
        repeat (100) @(posedge Clk);
        #2;
        Reset_n = 1'b0;
        #1;
        check("mid-clear reset clear_busy", 32'(clear_busy), 0);
        check("mid-clear reset color_valid", 32'(color_valid), 0);
        check("mid-clear reset color_enum", 32'(color_enum), 32'(BLANK_COLOR));
        check("mid-clear reset wr_ready", 32'(wr_if.wr_ready), 0);
        de = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        @(posedge Clk);
        #1;
        check("wr_ready after mid-clear reset", 32'(wr_if.wr_ready), 1);
        check("clear_busy after mid-clear reset", 32'(clear_busy), 0);
        px(0, 0, 1'b1, 8'hFF, 4'h3, 1'b1);
        px(200, 0, 1'b1, 8'hFF, 4'h3, 1'b1);
        px(639, 479, 1'b1, 8'hFF, 4'hA, 1'b1);
        px(0, 100, 1'b1, 8'hFF, 4'hA, 1'b1);
        idle(6);

        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            guard++;
            @(posedge Clk);
        end
        if (sb.size() > 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard drain: %0d pixels outstanding, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
